serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing diff = a - b, LSB first, one bit per clock; it is the inverse operation of the adder cells.
- A single registered borrow flop chains the bits.
- A start/busy/done handshake lets a controller or testbench launch one subtraction at a time.
- Used where area matters more than latency, and as the subtract path paired with the existing adder blocks.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range ≥ 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while state is SHIFT or DONE.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result, (a - b) mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff a < b (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, busy=0, done=0, diff=0, borrow=0, bit counter=0.
  - Internal operand shift registers cleared.
- Reset takes effect immediately, including mid-SHIFT. The partial result is discarded and no done pulse is issued.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - busy=0.
  - When start=1 on a rising edge: latch a and b into shift registers, clear the internal borrow flop and the counter, go to SHIFT.
  - When start=0: stay in IDLE; diff and borrow hold the last result.
- SHIFT (exactly WIDTH clock edges):
  - Each edge operates on bit i = current LSB of the a and b shift registers.
  - d = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d is shifted into diff from the MSB end; both operand registers shift right by 1; counter increments.
  - On the edge where counter == WIDTH-1: go to DONE and copy br_next to the borrow output.
- DONE (one cycle):
  - done=1, busy=1; diff and borrow are final.
  - Next edge returns to IDLE unconditionally.
- Latency: start sampled at edge k; done is high during the cycle after edge k+WIDTH. Start-to-start throughput is WIDTH+2 cycles.
- start while busy (SHIFT or DONE) is ignored; no queuing. a and b may change freely after the accepting edge.
- diff is not guaranteed stable during SHIFT; consumers sample it only when done=1 or in IDLE after done.
- borrow output holds its previous value until the DONE transition.
- Widths: no sign extension; arithmetic is modulo 2^WIDTH.
- WIDTH=1: SHIFT lasts one edge; the counter may be 1 bit.
- Counter width: $clog2(WIDTH), minimum 1.

Decomposition:
- Shared package / include: the state localparams (S_IDLE=0, S_SHIFT=1, S_DONE=2) and the counter-width function, so the future serial adder reuses them.
- One combinational sub-module, full_subtractor (x, y, bin -> d, bout). It is the subtract counterpart of the adder bit cells, with its own small exhaustive bench.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan:
- WIDTH=8, a=100, b=37, start pulsed 1 cycle:
  - busy rises the next cycle.
  - done pulses exactly 8 cycles after the accepting edge.
  - diff=63, borrow=0.
- a=5, b=9 → diff=252, borrow=1. Then a=0, b=255 → diff=1, borrow=1. Then a=255, b=255 → diff=0, borrow=0.
- a=0, b=0 → diff=0, borrow=0. done is a single-cycle pulse and busy falls the cycle after done.
- start re-asserted every cycle during SHIFT with a=1, b=1:
  - Only the first request is processed (a=200, b=50 → diff=150).
  - A second operation begins only after return to IDLE.
- rst_n pulled low at SHIFT bit 3 of a 7-2 operation:
  - All outputs go to 0 immediately; no done pulse.
  - After release, a fresh start with a=7, b=2 yields diff=5, borrow=0.
- WIDTH=1 instance, all four (a,b) pairs → (0,0)=0/0, (1,0)=1/0, (0,1)=1/1, (1,1)=0/0, each with done one cycle after the accepting edge.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// The serial adder reuses the state encoding and the counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // A single-bit operand still needs a 1-bit counter.
  function automatic int cntWidth(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
// This is the subtract counterpart of the adder bit cells.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// The start/busy/done handshake accepts one operation at a time.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = cntWidth(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] w_diffShift;
  logic [CNT_W-1:0] r_count;
  logic             r_br;
  logic             r_borrow;
  logic             w_d;
  logic             w_brNext;
  logic             w_lastBit;

  full_subtractor u_fullSub (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_brNext)
  );

  assign w_lastBit = (r_count == CNT_W'(WIDTH - 1));

  // Each result bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
  generate
    if (WIDTH == 1) begin : gen_diffOne
      assign w_diffShift = w_d;
    end else begin : gen_diffMany
      assign w_diffShift = {w_d, r_diff[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_SHIFT;
      S_SHIFT: if (w_lastBit) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // The borrow output only moves on the final bit, so it keeps the previous result during SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_count  <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_a     <= a;
      r_b     <= b;
      r_br    <= 1'b0;
      r_count <= '0;
    end else if (r_state == S_SHIFT) begin
      r_diff  <= w_diffShift;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_br    <= w_brNext;
      r_count <= r_count + CNT_W'(1);
      if (w_lastBit) r_borrow <= w_brNext;
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=1) and its full_subtractor cell.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;

  logic       start1;
  logic       a1;
  logic       b1;
  logic       busy1;
  logic       done1;
  logic       diff1;
  logic       borrow1;

  logic       fsX;
  logic       fsY;
  logic       fsBin;
  logic       fsD;
  logic       fsBout;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  serial_subtractor #(.WIDTH(1)) dutW1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1)
  );

  full_subtractor dutFs (
    .x    (fsX),
    .y    (fsY),
    .bin  (fsBin),
    .d    (fsD),
    .bout (fsBout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one cycle, then scrambles the operands to show they were captured.
  task automatic launch8(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = 8'h5A;
    b = 8'hC3;
  endtask

  task automatic waitDone8(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++;
    if (diff !== 8'd0) begin errors++; $display("[TB] FAIL reset_diff got %0d want 0", diff); end
    checks++;
    if (borrow !== 1'b0) begin errors++; $display("[TB] FAIL reset_borrow got %b want 0", borrow); end
  endtask

  task automatic test_basic;
    int n;
    launch8(8'd100, 8'd37);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_rise got %b want 1", busy); end
    waitDone8(n);
    checks++;
    if (n != 8) begin errors++; $display("[TB] FAIL basic_latency got %0d want 8", n); end
    checks++;
    if (diff !== 8'd63) begin errors++; $display("[TB] FAIL basic_diff got %0d want 63", diff); end
    checks++;
    if (borrow !== 1'b0) begin errors++; $display("[TB] FAIL basic_borrow got %b want 0", borrow); end
    repeat (3) @(negedge clk);
    checks++;
    if (diff !== 8'd63 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold got diff=%0d busy=%b want 63/0", diff, busy);
    end
  endtask

  task automatic test_borrow;
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic [7:0] dv [3];
    logic       brv [3];
    int n;
    av = '{8'd5, 8'd0, 8'd255};
    bv = '{8'd9, 8'd255, 8'd255};
    dv = '{8'd252, 8'd1, 8'd0};
    brv = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      launch8(av[i], bv[i]);
      if (i == 2) begin
        checks++;
        if (borrow !== 1'b1) begin errors++; $display("[TB] FAIL borrow_hold got %b want 1", borrow); end
      end
      waitDone8(n);
      checks++;
      if (n != 8) begin errors++; $display("[TB] FAIL borrow_latency[%0d] got %0d want 8", i, n); end
      checks++;
      if (diff !== dv[i]) begin errors++; $display("[TB] FAIL borrow_diff[%0d] got %0d want %0d", i, diff, dv[i]); end
      checks++;
      if (borrow !== brv[i]) begin errors++; $display("[TB] FAIL borrow_out[%0d] got %b want %b", i, borrow, brv[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_zero;
    int n;
    launch8(8'd0, 8'd0);
    waitDone8(n);
    checks++;
    if (diff !== 8'd0 || borrow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_result got %0d/%b want 0/0", diff, borrow);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_pulse got %b want 0", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy_fall got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    start = 1'b1;
    a = 8'd200;
    b = 8'd50;
    @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    waitDone8(n);
    checks++;
    if (n != 8) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 8", n); end
    checks++;
    if (diff !== 8'd150) begin errors++; $display("[TB] FAIL b2b_diff got %0d want 150", diff); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got busy=%b want 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_start got busy=%b want 1", busy); end
    start = 1'b0;
    waitDone8(n);
    checks++;
    if (n != 8 || diff !== 8'd0 || borrow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second got n=%0d diff=%0d borrow=%b want 8/0/0", n, diff, borrow);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    int seenDone;
    launch8(8'd7, 8'd2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || borrow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_clear got busy=%b done=%b diff=%0d borrow=%b want all 0",
               busy, done, diff, borrow);
    end
    seenDone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seenDone++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) seenDone++;
    end
    checks++;
    if (seenDone != 0) begin errors++; $display("[TB] FAIL midreset_no_done got %0d pulses want 0", seenDone); end
    launch8(8'd7, 8'd2);
    waitDone8(n);
    checks++;
    if (n != 8 || diff !== 8'd5 || borrow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_fresh got n=%0d diff=%0d borrow=%b want 8/5/0", n, diff, borrow);
    end
    @(negedge clk);
  endtask

  task automatic test_width1;
    logic av [4];
    logic bv [4];
    logic dv [4];
    logic brv [4];
    int n;
    av = '{1'b0, 1'b1, 1'b0, 1'b1};
    bv = '{1'b0, 1'b0, 1'b1, 1'b1};
    dv = '{1'b0, 1'b1, 1'b1, 1'b0};
    brv = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      start1 = 1'b1;
      a1 = av[i];
      b1 = bv[i];
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~av[i];
      b1 = ~bv[i];
      n = 0;
      while (done1 !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n != 1) begin errors++; $display("[TB] FAIL w1_latency[%0d] got %0d want 1", i, n); end
      checks++;
      if (diff1 !== dv[i] || borrow1 !== brv[i]) begin
        errors++;
        $display("[TB] FAIL w1_result[%0d] got %b/%b want %b/%b", i, diff1, borrow1, dv[i], brv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_full_subtractor;
    logic [1:0] expv [8];
    expv = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    for (int i = 0; i < 8; i++) begin
      {fsX, fsY, fsBin} = 3'(i);
      #1;
      checks++;
      if ({fsD, fsBout} !== expv[i]) begin
        errors++;
        $display("[TB] FAIL fullsub[%0d] got d/bout=%b want %b", i, {fsD, fsBout}, expv[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    start1 = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    fsX = 1'b0;
    fsY = 1'b0;
    fsBin = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_borrow();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    test_full_subtractor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
